// File: rtl/pipelined_fadd.sv
// Four-stage IEEE-754 single-precision adder/subtractor (unpack, align, add, normalize/round/pack).
// Define PFADD_RNE_EN for round-to-nearest-even; otherwise results truncate and overflow saturates.
module pipelined_fadd (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        operation,
   output logic [31:0] result
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   // Leading-zero count of a 27-bit mantissa; highest set bit wins.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) begin
            n = 5'(26 - i);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // ---------------- S1: unpack, classify, order by magnitude ----------------
   logic        sa_s, sb_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_ge_b_s;
   logic [7:0]  ea_s, eb_s;
   logic [23:0] ma_s, mb_s;
   logic [30:0] mag_a_s, mag_b_s;
   logic        spec_s;
   logic [31:0] spec_val_s;

   logic        s1_spec_r, s1_sign_r, s1_sub_r, s1_bz_r, s1_zsign_r;
   logic [31:0] s1_spec_val_r;
   logic [7:0]  s1_ebig_r, s1_esml_r;
   logic [23:0] s1_mbig_r, s1_msml_r;

   // Operand unpack and special-value classification.
   always_comb begin
      sa_s     = A[31];
      sb_s     = B[31] ^ operation;
      ea_s     = A[30:23];
      eb_s     = B[30:23];
      ma_s     = (ea_s == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
      mb_s     = (eb_s == 8'd0) ? 24'd0 : {1'b1, B[22:0]};
      mag_a_s  = (ea_s == 8'd0) ? 31'd0 : A[30:0];
      mag_b_s  = (eb_s == 8'd0) ? 31'd0 : B[30:0];
      a_ge_b_s = (mag_a_s >= mag_b_s);
      a_nan_s  = (ea_s == 8'hFF) && (A[22:0] != 23'd0);
      b_nan_s  = (eb_s == 8'hFF) && (B[22:0] != 23'd0);
      a_inf_s  = (ea_s == 8'hFF) && (A[22:0] == 23'd0);
      b_inf_s  = (eb_s == 8'hFF) && (B[22:0] == 23'd0);
      spec_s     = 1'b1;
      spec_val_s = QNAN;
      if (a_nan_s || b_nan_s) begin
         spec_val_s = QNAN;
      end else if (a_inf_s && b_inf_s) begin
         spec_val_s = (sa_s == sb_s) ? {sa_s, 8'hFF, 23'd0} : QNAN;
      end else if (a_inf_s) begin
         spec_val_s = {sa_s, 8'hFF, 23'd0};
      end else if (b_inf_s) begin
         spec_val_s = {sb_s, 8'hFF, 23'd0};
      end else begin
         spec_s     = 1'b0;
         spec_val_s = 32'd0;
      end
   end

   // Stage-1 register: larger-magnitude operand is placed first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_spec_r     <= 1'b0;
         s1_spec_val_r <= 32'd0;
         s1_sign_r     <= 1'b0;
         s1_sub_r      <= 1'b0;
         s1_bz_r       <= 1'b0;
         s1_zsign_r    <= 1'b0;
         s1_ebig_r     <= 8'd0;
         s1_esml_r     <= 8'd0;
         s1_mbig_r     <= 24'd0;
         s1_msml_r     <= 24'd0;
      end else begin
         s1_spec_r     <= spec_s;
         s1_spec_val_r <= spec_val_s;
         s1_sub_r      <= sa_s ^ sb_s;
         s1_bz_r       <= (ea_s == 8'd0) && (eb_s == 8'd0);
         s1_zsign_r    <= sa_s & sb_s;
         if (a_ge_b_s) begin
            s1_sign_r <= sa_s;
            s1_ebig_r <= ea_s;
            s1_esml_r <= eb_s;
            s1_mbig_r <= ma_s;
            s1_msml_r <= mb_s;
         end else begin
            s1_sign_r <= sb_s;
            s1_ebig_r <= eb_s;
            s1_esml_r <= ea_s;
            s1_mbig_r <= mb_s;
            s1_msml_r <= ma_s;
         end
      end
   end

   // ---------------- S2: align smaller mantissa ----------------
   logic [7:0]  d_s;
   logic [49:0] sh_s;
   logic [26:0] algn_s;

   logic        s2_spec_r, s2_sign_r, s2_sub_r, s2_bz_r, s2_zsign_r;
   logic [31:0] s2_spec_val_r;
   logic [7:0]  s2_exp_r;
   logic [26:0] s2_mbig_r, s2_msml_r;

   // Right shift keeping guard/round in the low field and OR-ing the rest into sticky.
   always_comb begin
      d_s  = s1_ebig_r - s1_esml_r;
      sh_s = {s1_msml_r, 26'd0} >> d_s;
      if (d_s >= 8'd26) begin
         algn_s = {26'd0, |s1_msml_r};
      end else begin
         algn_s = {sh_s[49:24], |sh_s[23:0]};
      end
   end

   // Stage-2 register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_spec_r     <= 1'b0;
         s2_spec_val_r <= 32'd0;
         s2_sign_r     <= 1'b0;
         s2_sub_r      <= 1'b0;
         s2_bz_r       <= 1'b0;
         s2_zsign_r    <= 1'b0;
         s2_exp_r      <= 8'd0;
         s2_mbig_r     <= 27'd0;
         s2_msml_r     <= 27'd0;
      end else begin
         s2_spec_r     <= s1_spec_r;
         s2_spec_val_r <= s1_spec_val_r;
         s2_sign_r     <= s1_sign_r;
         s2_sub_r      <= s1_sub_r;
         s2_bz_r       <= s1_bz_r;
         s2_zsign_r    <= s1_zsign_r;
         s2_exp_r      <= s1_ebig_r;
         s2_mbig_r     <= {s1_mbig_r, 3'b000};
         s2_msml_r     <= algn_s;
      end
   end

   // ---------------- S3: add or subtract magnitudes ----------------
   logic [27:0] sum_s;

   logic        s3_spec_r, s3_sign_r, s3_bz_r, s3_zsign_r;
   logic [31:0] s3_spec_val_r;
   logic [7:0]  s3_exp_r;
   logic [27:0] s3_sum_r;

   // Larger minus smaller never goes negative because of the S1 ordering.
   always_comb begin
      if (s2_sub_r) begin
         sum_s = {1'b0, s2_mbig_r} - {1'b0, s2_msml_r};
      end else begin
         sum_s = {1'b0, s2_mbig_r} + {1'b0, s2_msml_r};
      end
   end

   // Stage-3 register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_spec_r     <= 1'b0;
         s3_spec_val_r <= 32'd0;
         s3_sign_r     <= 1'b0;
         s3_bz_r       <= 1'b0;
         s3_zsign_r    <= 1'b0;
         s3_exp_r      <= 8'd0;
         s3_sum_r      <= 28'd0;
      end else begin
         s3_spec_r     <= s2_spec_r;
         s3_spec_val_r <= s2_spec_val_r;
         s3_sign_r     <= s2_sign_r;
         s3_bz_r       <= s2_bz_r;
         s3_zsign_r    <= s2_zsign_r;
         s3_exp_r      <= s2_exp_r;
         s3_sum_r      <= sum_s;
      end
   end

   // ---------------- S4: normalize, round, pack ----------------
   logic [4:0]        lz_s;
   logic [26:0]       norm_s;
   logic signed [9:0] enorm_s, efin_s;
   logic              rup_s;
   logic [24:0]       rnd_s;
   logic [22:0]       frac_s;
   logic [31:0]       s4_val_s;

   // Normalization, rounding and final result selection.
   always_comb begin
      lz_s = lzc27(s3_sum_r[26:0]);
      if (s3_sum_r[27]) begin
         norm_s  = {s3_sum_r[27:2], s3_sum_r[1] | s3_sum_r[0]};
         enorm_s = $signed({2'b00, s3_exp_r}) + 10'sd1;
      end else begin
         norm_s  = s3_sum_r[26:0] << lz_s;
         enorm_s = $signed({2'b00, s3_exp_r}) - $signed({5'd0, lz_s});
      end
`ifdef PFADD_RNE_EN
      rup_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
`else
      rup_s = 1'b0;
`endif
      rnd_s = {1'b0, norm_s[26:3]} + {24'd0, rup_s};
      if (rnd_s[24]) begin
         efin_s = enorm_s + 10'sd1;
         frac_s = rnd_s[23:1];
      end else begin
         efin_s = enorm_s;
         frac_s = rnd_s[22:0];
      end

      if (s3_spec_r) begin
         s4_val_s = s3_spec_val_r;
      end else if (s3_sum_r == 28'd0) begin
         // Exact cancellation is +0; only two zero operands can keep a negative sign.
         s4_val_s = {s3_bz_r & s3_zsign_r, 31'd0};
      end else if (efin_s < 10'sd1) begin
         s4_val_s = {s3_sign_r, 31'd0};
      end else if (efin_s >= 10'sd255) begin
`ifdef PFADD_RNE_EN
         s4_val_s = {s3_sign_r, 8'hFF, 23'd0};
`else
         s4_val_s = {s3_sign_r, 8'hFE, 23'h7FFFFF};
`endif
      end else begin
         s4_val_s = {s3_sign_r, efin_s[7:0], frac_s};
      end
   end

   // Output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= 32'd0;
      end else begin
         result <= s4_val_s;
      end
   end

endmodule

// File: tb/tb_pipelined_fadd.sv
// Scoreboard bench for pipelined_fadd: directed vectors pushed to a queue, monitor compares on output.
module tb_pipelined_fadd;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B;
   logic        operation;
   logic [31:0] result;

   pipelined_fadd dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .operation (operation),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] rne;
      logic [31:0] trn;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      int          idx;
   } exp_t;

   localparam int NV = 21;
   vec_t vecs [NV] = '{
      '{32'h415A6666, 32'h41241687, 1'b0, 32'h41BF3E76, 32'h41BF3E76},
      '{32'h415A6666, 32'h41241687, 1'b1, 32'h40593F7C, 32'h40593F7C},
      '{32'hC15A6666, 32'h41241687, 1'b0, 32'hC0593F7C, 32'hC0593F7C},
      '{32'hC15A6666, 32'h41241687, 1'b1, 32'hC1BF3E76, 32'hC1BF3E76},
      '{32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'h00000000},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 32'h7FC00000},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 32'h3F800000},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 32'h3F800001},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 32'h80000000},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 32'h7F7FFFFF},
      '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 32'hFF7FFFFF},
      '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 32'h80000000},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 32'h3F800000},
      '{32'h3F800000, 32'h2F800000, 1'b1, 32'h3F800000, 32'h3F7FFFFF},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 32'h7FC00000},
      '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 32'h7FC00000},
      '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 32'hFF800000},
      '{32'hBFC00000, 32'h3F800000, 1'b0, 32'hBF000000, 32'hBF000000},
      '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 32'h40000000},
      '{32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 32'h3F800000}
   };

   exp_t       expq [$];
   logic       issue;
   logic [3:0] vpipe;
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: result=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic issue_vec(input int i);
      exp_t e;
      @(negedge clk);
      A         = vecs[i].a;
      B         = vecs[i].b;
      operation = vecs[i].op;
      issue     = 1'b1;
`ifdef PFADD_RNE_EN
      e.exp = vecs[i].rne;
`else
      e.exp = vecs[i].trn;
`endif
      e.idx = i;
      expq.push_back(e);
   endtask

   task automatic go_idle();
      A         = 32'd0;
      B         = 32'd0;
      operation = 1'b0;
      issue     = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && expq.size() != 0; k++) @(negedge clk);
      if (expq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d results outstanding, expected 0", expq.size());
      end
   endtask

   // Tracks which result cycles carry an issued operation.
   always @(posedge clk or posedge rst) begin
      if (rst) vpipe <= 4'd0;
      else     vpipe <= {vpipe[2:0], issue};
   end

   // Monitor: pops and compares whenever an issued operation reaches the output.
   always @(negedge clk) begin
      if (!rst && vpipe[3]) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected: result=%08h with empty scoreboard", result);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check($sformatf("vec%0d", e.idx), result, e.exp);
         end
      end
   end

   initial begin
      rst = 1'b1;
      go_idle();
      repeat (2) @(negedge clk);
      check("reset_state", result, 32'h00000000);
      rst = 1'b0;

      // Back-to-back issue exercises full throughput and ordering.
      for (int i = 0; i < NV; i++) issue_vec(i);
      @(negedge clk);
      go_idle();
      drain();

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) issue_vec(i + 8);
      @(negedge clk);
      rst = 1'b1;
      go_idle();
      expq.delete();
      #1;
      check("rst_async", result, 32'h00000000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("post_rst_idle%0d", k), result, 32'h00000000);
      end

      issue_vec(0);
      @(negedge clk);
      go_idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
